reg_scoreboard: RTL and testbench

- Write-side tracker for the pipelined RV32I register file.
- Counts in-flight writes to each architectural register. Decode issues an instruction's destination here; writeback retires it on the same RegWrite/rd event that writes the register file; flushes release squashed instructions.
- Decode queries rs1/rs2 against the outstanding counts and raises stall until the producing write has reached the register file.

---
 rtl/reg_scoreboard_if.sv | 38 +++
 rtl/reg_scoreboard.sv | 96 +++++++++
 tb/tb_reg_scoreboard.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/flush bundle between the pipeline and the register write scoreboard.
// The pipeline drives through master; the scoreboard takes the slave view.
interface reg_scoreboard_if #(
    parameter int NUM_REGS = 32
);
    localparam int AW = $clog2(NUM_REGS);

    logic            issue_valid;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic            issue_use_rs1;
    logic            issue_use_rs2;
    logic            issue_reg_write;
    logic [AW-1:0]   issue_rd;
    logic            wb_reg_write;
    logic [AW-1:0]   wb_rd;
    logic            kill0_valid;
    logic [AW-1:0]   kill0_rd;
    logic            kill1_valid;
    logic [AW-1:0]   kill1_rd;
    logic            stall;
    logic [NUM_REGS-1:0] busy;
    logic            err;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_reg_write, issue_rd, wb_reg_write, wb_rd,
               kill0_valid, kill0_rd, kill1_valid, kill1_rd,
        input  stall, busy, err
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_reg_write, issue_rd, wb_reg_write, wb_rd,
               kill0_valid, kill0_rd, kill1_valid, kill1_rd,
        output stall, busy, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-write counters for the RV32I pipeline.
// Raises stall on RAW hazards and on destination-counter saturation.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input logic           clk,
    input logic           rst,
    reg_scoreboard_if.slave sb
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic                err_q, err_d;
    logic                haz_rs1, haz_rs2, haz_rd;
    logic                stall_w, accept;
    logic [NUM_REGS-1:0] inc_v, wb_v, k0_v, k1_v;
    logic [NUM_REGS-1:0] busy_w;

    function automatic logic [NUM_REGS-1:0] onehot(input logic en, input logic [AW-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (en) v[idx] = 1'b1;
        v[0] = 1'b0;
        return v;
    endfunction

    // A count of exactly one that retires this cycle is readable: the regfile writes on negedge.
    always_comb begin
        haz_rs1 = sb.issue_use_rs1 && (sb.issue_rs1 != '0) && (cnt_q[sb.issue_rs1] != '0)
                  && !((cnt_q[sb.issue_rs1] == CNT_W'(1)) && sb.wb_reg_write
                       && (sb.wb_rd == sb.issue_rs1));
        haz_rs2 = sb.issue_use_rs2 && (sb.issue_rs2 != '0) && (cnt_q[sb.issue_rs2] != '0)
                  && !((cnt_q[sb.issue_rs2] == CNT_W'(1)) && sb.wb_reg_write
                       && (sb.wb_rd == sb.issue_rs2));
        haz_rd  = sb.issue_reg_write && (sb.issue_rd != '0) && (cnt_q[sb.issue_rd] == CNT_MAX);
        stall_w = sb.issue_valid && (haz_rs1 || haz_rs2 || haz_rd);
        accept  = sb.issue_valid && !stall_w;
    end

    always_comb begin
        inc_v = onehot(accept && sb.issue_reg_write, sb.issue_rd);
        wb_v  = onehot(sb.wb_reg_write, sb.wb_rd);
        k0_v  = onehot(sb.kill0_valid, sb.kill0_rd);
        k1_v  = onehot(sb.kill1_valid, sb.kill1_rd);
    end

    // Events are summed, not prioritised; out-of-range results saturate and flag err.
    always_comb begin
        int sum;
        sum   = 0;
        err_d = err_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = '0;
        end
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            sum = int'(cnt_q[r]) + int'(inc_v[r]) - int'(wb_v[r]) - int'(k0_v[r]) - int'(k1_v[r]);
            if (sum < 0) begin
                cnt_d[r] = '0;
                err_d    = 1'b1;
            end else if (sum > int'(CNT_MAX)) begin
                cnt_d[r] = CNT_MAX;
                err_d    = 1'b1;
            end else begin
                cnt_d[r] = CNT_W'(sum);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        busy_w = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            busy_w[r] = |cnt_q[r];
        end
    end

    assign sb.stall = stall_w;
    assign sb.busy  = busy_w;
    assign sb.err   = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: stimulus pushes expected stall/busy/err from a count model; a monitor pops and compares.
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_scoreboard_if #(.NUM_REGS(32)) bus ();

    reg_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    typedef struct {
        logic        stall;
        logic [31:0] busy;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   mcnt[32];
    bit   merr;
    int   n_chk = 0;
    int   n_pass = 0;

    // stimulus for the next cycle
    bit       s_rst, s_iv, s_u1, s_u2, s_rw, s_wbw, s_k0, s_k1;
    bit [4:0] s_rs1, s_rs2, s_rd, s_wbrd, s_k0rd, s_k1rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic clr();
        s_iv = 0; s_u1 = 0; s_u2 = 0; s_rw = 0; s_wbw = 0; s_k0 = 0; s_k1 = 0;
        s_rs1 = 0; s_rs2 = 0; s_rd = 0; s_wbrd = 0; s_k0rd = 0; s_k1rd = 0;
    endtask

    function automatic bit src_blocked(bit use_s, bit [4:0] s);
        if (!use_s || s == 0 || mcnt[s] == 0) return 0;
        if (mcnt[s] == 1 && s_wbw && s_wbrd == s) return 0;
        return 1;
    endfunction

    // One cycle: drive at negedge, record what the outputs must be, then advance the model past posedge.
    task automatic step();
        exp_t e;
        int   d[32];
        int   n;
        bit   st;
        @(negedge clk);
        rst = s_rst;
        bus.issue_valid = s_iv;  bus.issue_rs1 = s_rs1;  bus.issue_rs2 = s_rs2;
        bus.issue_use_rs1 = s_u1; bus.issue_use_rs2 = s_u2;
        bus.issue_reg_write = s_rw; bus.issue_rd = s_rd;
        bus.wb_reg_write = s_wbw; bus.wb_rd = s_wbrd;
        bus.kill0_valid = s_k0; bus.kill0_rd = s_k0rd;
        bus.kill1_valid = s_k1; bus.kill1_rd = s_k1rd;
        st = s_iv && (src_blocked(s_u1, s_rs1) || src_blocked(s_u2, s_rs2)
                      || (s_rw && s_rd != 0 && mcnt[s_rd] == 3));
        e.stall = st;
        e.busy  = '0;
        for (int r = 1; r < 32; r++) if (mcnt[r] != 0) e.busy[r] = 1'b1;
        e.err = merr;
        q.push_back(e);
        if (!s_rst) begin
            for (int r = 0; r < 32; r++) d[r] = 0;
            if (s_iv && !st && s_rw) d[s_rd]++;
            if (s_wbw) d[s_wbrd]--;
            if (s_k0)  d[s_k0rd]--;
            if (s_k1)  d[s_k1rd]--;
            for (int r = 1; r < 32; r++) begin
                n = mcnt[r] + d[r];
                if (n < 0)      begin n = 0; merr = 1; end
                else if (n > 3) begin n = 3; merr = 1; end
                mcnt[r] = n;
            end
        end
    endtask

    // Reset lands mid-cycle after this cycle's sample; outputs must clear before the next edge.
    task automatic mid_reset();
        #3;
        rst = 1'b1;
        s_rst = 1;
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        merr = 0;
        #1;
        chk("async_rst_busy", bus.busy, 32'h0);
        chk("async_rst_stall", {31'h0, bus.stall}, 32'h0);
        chk("async_rst_err", {31'h0, bus.err}, 32'h0);
        step();
        s_rst = 0;
    endtask

    function automatic bit [4:0] pick_busy();
        bit [4:0] cand[$];
        for (int r = 1; r < 8; r++) if (mcnt[r] != 0) cand.push_back(5'(r));
        if (cand.size() == 0) return 5'($urandom_range(0, 7));
        return cand[$urandom_range(0, cand.size() - 1)];
    endfunction

    always begin : monitor
        exp_t e;
        @(negedge clk);
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall", {31'h0, bus.stall}, {31'h0, e.stall});
            chk("busy", bus.busy, e.busy);
            chk("err", {31'h0, bus.err}, {31'h0, e.err});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        merr = 0;
        rst = 1'b1;
        clr();
        s_rst = 1;
        step();
        step();
        s_rst = 0;

        // issue rd=5, then read it with and without a same-cycle retire
        s_iv = 1; s_rw = 1; s_rd = 5; step(); clr();
        s_iv = 1; s_u1 = 1; s_rs1 = 5; step();
        s_wbw = 1; s_wbrd = 5; step(); clr();
        step();

        // saturate rd=7, blocked fourth issue, then retire one
        s_iv = 1; s_rw = 1; s_rd = 7;
        step(); step(); step();
        s_wbw = 1; s_wbrd = 7; step();
        s_wbw = 0; step(); clr();
        step();

        // inc, wb and kill0 on rd=9 together from a count of two
        s_iv = 1; s_rw = 1; s_rd = 9; step(); step();
        s_wbw = 1; s_wbrd = 9; s_k0 = 1; s_k0rd = 9; step(); clr();
        step();

        // retire on an idle register, then x0 traffic
        s_wbw = 1; s_wbrd = 12; step(); clr();
        s_iv = 1; s_rw = 1; s_rd = 0; s_u1 = 1; s_rs1 = 0; step();
        s_wbw = 1; s_wbrd = 0; s_k1 = 1; s_k1rd = 0; step(); clr();
        step();

        // two writes outstanding on x3 when reset hits
        s_iv = 1; s_rw = 1; s_rd = 3; step(); step();
        s_u1 = 1; s_rs1 = 3; s_rw = 0;
        step();
        mid_reset();
        clr();
        step();

        for (int i = 0; i < 800; i++) begin
            s_iv  = ($urandom_range(0, 9) < 7);
            s_u1  = $urandom_range(0, 1); s_rs1 = 5'($urandom_range(0, 7));
            s_u2  = $urandom_range(0, 1); s_rs2 = 5'($urandom_range(0, 7));
            s_rw  = ($urandom_range(0, 3) != 0); s_rd = 5'($urandom_range(0, 7));
            s_wbw = ($urandom_range(0, 9) < 4);
            s_wbrd = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(0, 31)) : pick_busy();
            s_k0  = ($urandom_range(0, 9) == 0); s_k0rd = pick_busy();
            s_k1  = ($urandom_range(0, 19) == 0); s_k1rd = pick_busy();
            step();
            if (i % 200 == 150) mid_reset();
        end
        clr();
        step();
        @(negedge clk);
        #4;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
